// File: rtl/cpu_pkg.sv
// Shared CPU encodings: load-extension ops, write-back source selects and
// the hardwired-zero register index.
package cpu_pkg;

  typedef enum logic [1:0] {
    LOAD_W  = 2'b00,  // full word, unchanged
    LOAD_B  = 2'b01,  // signed byte
    LOAD_H  = 2'b10,  // signed half
    LOAD_BU = 2'b11   // unsigned byte
  } load_op_e;

  typedef enum logic [1:0] {
    WD_AR  = 2'b00,   // ALU result
    WD_DM  = 2'b01,   // extended load data
    WD_PC8 = 2'b10,   // link address
    WD_CP0 = 2'b11    // mfc0 value
  } wd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_grf_load_ext.sv
// Load extractor: picks the addressed byte/half out of the raw DM word and
// sign- or zero-extends it to the datapath width.
module load_ext
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by full offset, half by offset[1] only.
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
    w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
  end

  // Extension according to the load type.
  always_comb begin
    o_data = i_data;
    case (i_op)
      LOAD_B:  o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LOAD_H:  o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LOAD_BU: o_data = {{(DATA_W-8){1'b0}}, w_byte};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage plus the general register file. W-stage results are
// bypassed straight into the D-stage read ports so D never stalls on a
// same-cycle write-back.
module wb_grf
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_N    = 32,
  parameter bit TRACE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       W_instr,
  input  logic [DATA_W-1:0] W_pc,
  input  logic [DATA_W-1:0] W_pc8,
  input  logic [4:0]        W_A3,
  input  logic [DATA_W-1:0] W_AR,
  input  logic [DATA_W-1:0] W_Datam,
  input  logic [DATA_W-1:0] W_CP0out,
  input  logic [1:0]        W_loadOp,
  input  logic [1:0]        W_wdSel,
  input  logic [4:0]        D_A1,
  input  logic [4:0]        D_A2,
  output logic [DATA_W-1:0] D_RD1,
  output logic [DATA_W-1:0] D_RD2,
  output logic [DATA_W-1:0] W_WD,
  output logic              W_we,
  output logic [DATA_W-1:0] trace_pc,
  output logic [4:0]        trace_reg,
  output logic [DATA_W-1:0] trace_data,
  output logic [31:0]       retire_cnt
);

  logic [REG_N-1:0][DATA_W-1:0] r_grf;
  logic [31:0]                  r_retire_cnt;
  logic [DATA_W-1:0]            w_ld_data;
  logic [DATA_W-1:0]            w_wd;
  logic                         w_we;

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .i_data (W_Datam),
    .i_off  (W_AR[1:0]),
    .i_op   (W_loadOp),
    .o_data (w_ld_data)
  );

  // Write-back source mux; bubbles carry A3 = 0 so they never enable a write.
  always_comb begin
    w_wd = W_AR;
    case (W_wdSel)
      WD_DM:   w_wd = w_ld_data;
      WD_PC8:  w_wd = W_pc8;
      WD_CP0:  w_wd = W_CP0out;
      default: w_wd = W_AR;
    endcase
    w_we = (W_A3 != REG_ZERO);
  end

  assign W_WD = w_wd;
  assign W_we = w_we;

  // Register file: async clear, reg 0 never written because w_we excludes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_grf <= '0;
    else if (w_we) r_grf[W_A3] <= w_wd;
  end

  // Read ports with same-cycle W bypass; address 0 always reads zero.
  always_comb begin
    D_RD1 = '0;
    D_RD2 = '0;
    if (D_A1 != REG_ZERO) D_RD1 = (D_A1 == W_A3) ? w_wd : r_grf[D_A1];
    if (D_A2 != REG_ZERO) D_RD2 = (D_A2 == W_A3) ? w_wd : r_grf[D_A2];
  end

  // Retire counter: every non-bubble instruction in W, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_retire_cnt <= '0;
    else if (W_instr != '0)   r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign retire_cnt = r_retire_cnt;

  // Trace mirrors the register write of this cycle, zero otherwise.
  generate
    if (TRACE_EN) begin : g_trace
      always_comb begin
        trace_pc   = '0;
        trace_reg  = '0;
        trace_data = '0;
        if (w_we) begin
          trace_pc   = W_pc;
          trace_reg  = W_A3;
          trace_data = w_wd;
        end
      end
    end else begin : g_no_trace
      assign trace_pc   = '0;
      assign trace_reg  = '0;
      assign trace_data = '0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: reset state, bypass/storage reads, load
// extension, write-back source selects, zero register, retire counting and
// asynchronous reset.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_instr, W_pc, W_pc8, W_AR, W_Datam, W_CP0out;
  logic [4:0]  W_A3, D_A1, D_A2;
  logic [1:0]  W_loadOp, W_wdSel;
  logic [31:0] D_RD1, D_RD2, W_WD, trace_pc, trace_data, retire_cnt;
  logic        W_we;
  logic [4:0]  trace_reg;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_grf dut (
    .clk(clk), .reset(reset),
    .W_instr(W_instr), .W_pc(W_pc), .W_pc8(W_pc8), .W_A3(W_A3),
    .W_AR(W_AR), .W_Datam(W_Datam), .W_CP0out(W_CP0out),
    .W_loadOp(W_loadOp), .W_wdSel(W_wdSel),
    .D_A1(D_A1), .D_A2(D_A2), .D_RD1(D_RD1), .D_RD2(D_RD2),
    .W_WD(W_WD), .W_we(W_we),
    .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
    .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    W_instr = '0; W_pc = '0; W_pc8 = '0; W_A3 = '0; W_AR = '0;
    W_Datam = '0; W_CP0out = '0; W_loadOp = '0; W_wdSel = '0;
  endtask

  task automatic ld(input logic [1:0] op, input logic [1:0] off, input logic [31:0] exp);
    W_loadOp = op;
    W_AR     = {30'h0, off};
    #1 check($sformatf("ld op%0d off%0d", op, off), W_WD, exp);
  endtask

  initial begin
    reset = 1'b1; idle(); D_A1 = '0; D_A2 = '0;

    // Reset state: every register reads zero, counter zero.
    #2 check("rst retire_cnt", retire_cnt, 32'd0);
    for (int i = 0; i < 32; i++) begin
      D_A1 = i[4:0]; D_A2 = i[4:0];
      #1 check($sformatf("rst rd1 r%0d", i), D_RD1, 32'd0);
      check($sformatf("rst rd2 r%0d", i), D_RD2, 32'd0);
    end
    @(negedge clk); reset = 1'b0;

    // Bypass of a same-cycle write, then read from storage.
    @(negedge clk);
    W_instr = 32'h0000_0021; W_pc = 32'h0000_3000; W_A3 = 5'd5;
    W_AR = 32'h1234_5678; W_wdSel = 2'b00; D_A1 = 5'd5;
    #1 check("bypass rd1", D_RD1, 32'h1234_5678);
    check("we a3=5", {31'h0, W_we}, 32'd1);
    check("trace_pc", trace_pc, 32'h0000_3000);
    check("trace_reg", {27'h0, trace_reg}, 32'd5);
    check("trace_data", trace_data, 32'h1234_5678);
    @(negedge clk); idle();
    #1 check("stored r5", D_RD1, 32'h1234_5678);
    check("retire after 1", retire_cnt, 32'd1);
    check("idle we", {31'h0, W_we}, 32'd0);

    // Bypass wins over the stale stored value.
    @(negedge clk);
    W_instr = 32'h1; W_A3 = 5'd5; W_AR = 32'hAAAA_5555; D_A2 = 5'd5;
    #1 check("bypass prio rd2", D_RD2, 32'hAAAA_5555);
    @(negedge clk); idle();
    #1 check("stored r5 new", D_RD2, 32'hAAAA_5555);
    check("retire after 2", retire_cnt, 32'd2);

    // Load extension, W idle so nothing is written.
    W_Datam = 32'h80FF_7F01; W_wdSel = 2'b01;
    ld(2'b01, 2'd3, 32'hFFFF_FF80);
    ld(2'b11, 2'd3, 32'h0000_0080);
    ld(2'b10, 2'd2, 32'hFFFF_80FF);
    ld(2'b10, 2'd0, 32'h0000_7F01);
    ld(2'b10, 2'd3, 32'hFFFF_80FF);
    ld(2'b00, 2'd1, 32'h80FF_7F01);
    ld(2'b01, 2'd1, 32'h0000_007F);
    ld(2'b01, 2'd0, 32'h0000_0001);
    ld(2'b11, 2'd2, 32'h0000_00FF);

    // Signed byte load written into r6.
    @(negedge clk);
    W_instr = 32'h2; W_A3 = 5'd6; W_Datam = 32'h80FF_7F01;
    W_wdSel = 2'b01; W_loadOp = 2'b01; W_AR = 32'h0000_1002;
    @(negedge clk); idle();

    // A3 = 0: no write, trace dark, zero register reads zero.
    W_instr = 32'h3; W_pc = 32'h0000_3020; W_A3 = 5'd0; W_AR = 32'hDEAD_BEEF;
    D_A1 = 5'd0; D_A2 = 5'd5;
    #1 check("a3=0 we", {31'h0, W_we}, 32'd0);
    check("a3=0 trace_pc", trace_pc, 32'd0);
    check("a3=0 trace_reg", {27'h0, trace_reg}, 32'd0);
    check("a3=0 trace_data", trace_data, 32'd0);
    check("a3=0 wd", W_WD, 32'hDEAD_BEEF);
    check("r0 reads 0", D_RD1, 32'd0);
    check("r5 no bypass", D_RD2, 32'hAAAA_5555);

    // Link value into r31.
    @(negedge clk);
    W_instr = 32'h4; W_A3 = 5'd31; W_wdSel = 2'b10; W_pc8 = 32'h0000_3010;
    W_AR = 32'h5555_0000;

    // CP0 value into r8 while r31 is read from storage.
    @(negedge clk);
    idle(); W_instr = 32'h5; W_A3 = 5'd8; W_wdSel = 2'b11; W_CP0out = 32'h0000_0024;
    D_A1 = 5'd31;
    #1 check("r31 pc8", D_RD1, 32'h0000_3010);
    check("wd cp0", W_WD, 32'h0000_0024);
    @(negedge clk); idle(); D_A1 = 5'd8; D_A2 = 5'd6;
    #1 check("r8 cp0", D_RD1, 32'h0000_0024);
    check("r6 lb", D_RD2, 32'hFFFF_FFFF);
    check("retire after 6", retire_cnt, 32'd6);

    // Reset pulse between edges clears state immediately.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("mid rst r8", D_RD1, 32'd0);
    check("mid rst r6", D_RD2, 32'd0);
    check("mid rst cnt", retire_cnt, 32'd0);
    #1 reset = 1'b0;

    // No write or count on an edge with reset held high.
    @(negedge clk);
    reset = 1'b1; W_instr = 32'h6; W_A3 = 5'd9; W_AR = 32'h0000_0077;
    @(negedge clk);
    reset = 1'b0; idle(); D_A1 = 5'd9;
    #1 check("rst edge r9", D_RD1, 32'd0);
    check("rst edge cnt", retire_cnt, 32'd0);

    // Three real instructions, two bubbles (one is a flush at 0x4180).
    @(negedge clk); W_instr = 32'h7; W_A3 = 5'd10; W_AR = 32'h1;
    @(negedge clk); idle();
    @(negedge clk); W_instr = 32'h8; W_A3 = 5'd0; W_AR = 32'h2;
    @(negedge clk); idle(); W_pc = 32'h0000_4180;
    @(negedge clk); idle(); W_instr = 32'h9; W_A3 = 5'd11; W_AR = 32'h3;
    @(negedge clk); idle(); D_A1 = 5'd10; D_A2 = 5'd11;
    #1 check("count 3", retire_cnt, 32'd3);
    check("r10", D_RD1, 32'h1);
    check("r11", D_RD2, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
